retire_trace_buffer: RTL and testbench
======================================

# retire_trace_buffer

Capture block sitting downstream of `main_module`: on every rising clock edge it samples the retiring instruction's observation signals (PC, instruction, write-back and store information) and pushes one trace entry into a small FIFO. A trigger FSM starts capture at a programmed PC, and a valid/ready port lets the bench or a debug reader drain the entries. It replaces waveform eyeballing with a checkable retirement log.

## Interface
- `DEPTH`, 8, number of FIFO entries; must be a power of 2 and at least 2.
- `clock`, in, 1, the single clock; all state changes on its rising edge.
- `reset`, in, 1, asynchronous, active-low; clears all state.
- `arm`, in, 1, level sampled per edge; requests IDLE/DONE→ARMED.
- `disarm`, in, 1, forces →IDLE; has priority over `arm`.
- `trig_pc`, in, 8, PC that starts capture.
- `stop_on_full`, in, 1, 1: stop capture when full; 0: keep running and drop entries.
- `cpu_pc`, in, 8, PC of the retiring instruction.
- `cpu_instr`, in, 8, instruction word.
- `cpu_reg_write`, in, 1, RegWrite.
- `cpu_mem_write`, in, 1, MemWrite.
- `cpu_wb_data`, in, 8, Mux2Output.
- `cpu_store_data`, in, 8, ReadData2.
- `cpu_alu_out`, in, 8, ALUOutput (store address).
- `out_valid`, out, 1, head entry available.
- `out_ready`, in, 1, consumer accepts the head entry.
- `out_pc`, out, 8, head entry PC.
- `out_instr`, out, 8, head entry instruction.
- `out_kind`, out, 2, head entry kind: {mem_write, reg_write}.
- `out_data`, out, 8, head entry data.
- `out_addr`, out, 8, head entry address.
- `state`, out, 2, FSM state: IDLE=0, ARMED=1, RUN=2, DONE=3.
- `count`, out, log2(DEPTH)+1, occupancy.
- `overflow`, out, 1, sticky flag: at least one entry was dropped.
- `dropped`, out, 8, number of dropped entries; saturates at 255.

## Operation
- Entry fields:
  - PC and instruction are copied from `cpu_pc` and `cpu_instr`.
  - kind = {cpu_mem_write, cpu_reg_write}.
  - data = `cpu_mem_write` ? `cpu_store_data` : `cpu_wb_data`.
  - addr = `cpu_alu_out`.
  - Kind 3 is recorded as-is, with store data.
- FSM transitions:
  - IDLE: `arm` → ARMED. On this transition `overflow` and `dropped` clear; FIFO contents are kept.
  - ARMED: on the edge where `cpu_pc` == `trig_pc`, that instruction is pushed as the first entry → RUN.
  - RUN: one push attempt per edge.
  - DONE: `arm` → ARMED, with the same clears as from IDLE.
  - `arm` is ignored in ARMED and RUN.
  - `disarm` → IDLE from any state, with no push on that edge.
- Push acceptance: a push is accepted if count < DEPTH, or if a pop occurs on the same edge.
- Full, stop_on_full=1: the edge that makes count = DEPTH moves RUN→DONE, so no entry is ever dropped.
- Full, stop_on_full=0: a rejected push sets `overflow` and increments `dropped`; the FSM stays in RUN.
- Pop: occurs when `out_valid` and `out_ready` are both high. Draining is allowed in every state.
- Simultaneous push and pop: count is unchanged, and the head advances.
- Empty: `out_valid`=0, `out_ready` is ignored, and the `out_*` fields are don't-care.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: `state`=IDLE, `count`=0, `out_valid`=0, `overflow`=0, `dropped`=0, pointers 0.
- An assertion of `reset` mid-capture discards all entries immediately.
- Push latency: an entry sampled at edge N is visible on `out_*` right after edge N when the FIFO was empty. The FIFO is first-word-fall-through.
- `out_valid` = (count != 0), combinational from registered count.
- `out_*` are read combinationally from the head slot, with no extra register stage.
- `count`, `state`, `overflow` and `dropped` update on the same edge as the event that changes them.
- Sampling is synchronous to the CPU clock edge, i.e. the values present just before that edge.

## Structure
- Shared package `trace_pkg`:
  - state encodings (IDLE/ARMED/RUN/DONE);
  - kind encodings (NONE=0, REG=1, STORE=2, BOTH=3);
  - entry field widths.
- One sub-module, `trace_fifo`:
  - parameterized DEPTH × 34-bit storage;
  - FWFT behaviour, with `push`, `pop`, `full` and `count`.
- The trigger/FSM and the drop counter live in `retire_trace_buffer`.

## Test plan
- **Reset, then trigger:** release `reset`, pulse `arm`, with trig_pc=0x02 and PC sequence 0,1,2,3.
  - Entries are recorded at PC 2 and 3 only.
  - `state` = RUN after the PC 2 edge.
  - First entry pc=0x02.
- **Kind and data:** a RegWrite retirement with wb_data=0x0A gives kind=1, data=0x0A. A store with store_data=0x55 and alu_out=0x07 gives kind=2, data=0x55, addr=0x07.
- **Stop on full:** stop_on_full=1, DEPTH=8, `out_ready`=0.
  - After 8 edges: count=8, `state`=DONE, `overflow`=0.
  - Further edges change nothing.
- **Drop mode:** stop_on_full=0, `out_ready`=0, 12 edges in RUN.
  - count=8, `overflow`=1, `dropped`=4.
  - Entries hold the first 8 PCs.
  - Re-arm clears `overflow` and `dropped`.
- **Full with simultaneous pop:** full FIFO, `out_ready`=1 for 3 edges in RUN.
  - Each edge pops the oldest entry and pushes a new one; count stays 8.
  - `dropped` is unchanged; the head advances by 3.
- **Reset and disarm mid-capture:**
  - Assert `reset` asynchronously with count=5: count=0, `out_valid`=0 and `state`=IDLE immediately, without waiting for a clock edge.
  - `disarm` asserted together with `arm` gives IDLE.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the retirement trace capture: FSM and kind encodings,
// entry field widths and the packed trace entry layout.
package trace_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 8;
   localparam int KIND_W  = 2;
   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 8;
   localparam int ENTRY_W = PC_W + INSTR_W + KIND_W + DATA_W + ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } trace_state_e;

   typedef enum logic [1:0] {
      KIND_NONE  = 2'd0,
      KIND_REG   = 2'd1,
      KIND_STORE = 2'd2,
      KIND_BOTH  = 2'd3
   } trace_kind_e;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic [KIND_W-1:0]  kind;
      logic [DATA_W-1:0]  data;
      logic [ADDR_W-1:0]  addr;
   } trace_entry_t;

   // Stores carry their store data; everything else carries the write-back value.
   function automatic trace_entry_t make_entry(
      input logic [PC_W-1:0]    pc,
      input logic [INSTR_W-1:0] instr,
      input logic               reg_write,
      input logic               mem_write,
      input logic [DATA_W-1:0]  wb_data,
      input logic [DATA_W-1:0]  store_data,
      input logic [ADDR_W-1:0]  alu_out
   );
      trace_entry_t e;
      e.pc    = pc;
      e.instr = instr;
      e.kind  = {mem_write, reg_write};
      e.data  = mem_write ? store_data : wb_data;
      e.addr  = alu_out;
      return e;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO holding packed trace entries; the head slot
// is presented combinationally on dout.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [ENTRY_W-1:0]       din,
   output logic [ENTRY_W-1:0]       dout,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != FULL_CNT) || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; occupancy alone decides what is valid.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == FULL_CNT);
   assign count = count_q;

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace capture: trigger FSM, drop accounting and a FWFT entry
// FIFO drained through a valid/ready port.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | not capturing; waits for arm
//   ST_ARMED | waiting for cpu_pc == trig_pc; that retirement is entry 0
//   ST_RUN   | one push attempt per edge; drops counted when full
//   ST_DONE  | capture stopped on full; arm restarts
module retire_trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       arm,
   input  logic                       disarm,
   input  logic [PC_W-1:0]            trig_pc,
   input  logic                       stop_on_full,
   input  logic [PC_W-1:0]            cpu_pc,
   input  logic [INSTR_W-1:0]         cpu_instr,
   input  logic                       cpu_reg_write,
   input  logic                       cpu_mem_write,
   input  logic [DATA_W-1:0]          cpu_wb_data,
   input  logic [DATA_W-1:0]          cpu_store_data,
   input  logic [ADDR_W-1:0]          cpu_alu_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_W-1:0]            out_pc,
   output logic [INSTR_W-1:0]         out_instr,
   output logic [KIND_W-1:0]          out_kind,
   output logic [DATA_W-1:0]          out_data,
   output logic [ADDR_W-1:0]          out_addr,
   output logic [1:0]                 state,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic [7:0]                 dropped
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

   trace_state_e       state_q, state_d;
   logic               overflow_q, overflow_d;
   logic [7:0]         dropped_q, dropped_d;
   logic               push_req, push_ok, pop_fire, fills, fifo_full;
   logic [CNT_W-1:0]   fifo_count;
   trace_entry_t       entry_in, head;
   logic [ENTRY_W-1:0] fifo_dout;

   assign entry_in = make_entry(cpu_pc, cpu_instr, cpu_reg_write, cpu_mem_write,
                                cpu_wb_data, cpu_store_data, cpu_alu_out);

   assign pop_fire = out_valid && out_ready;
   assign push_req = !disarm &&
                     (((state_q == ST_ARMED) && (cpu_pc == trig_pc)) || (state_q == ST_RUN));
   assign push_ok  = push_req && (!fifo_full || pop_fire);
   // Only a net +1 from DEPTH-1 reaches full; push+pop at full does not.
   assign fills    = push_ok && !pop_fire && (fifo_count == LAST_CNT);

   always_comb begin
      state_d    = state_q;
      overflow_d = overflow_q;
      dropped_d  = dropped_q;
      if (disarm) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (arm) begin
                  state_d    = ST_ARMED;
                  overflow_d = 1'b0;
                  dropped_d  = '0;
               end
            end
            ST_ARMED, ST_RUN: begin
               if (push_req) begin
                  state_d = ST_RUN;
                  if (!push_ok) begin
                     if (stop_on_full) begin
                        state_d = ST_DONE;
                     end else begin
                        overflow_d = 1'b1;
                        if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
                     end
                  end else if (fills && stop_on_full) begin
                     state_d = ST_DONE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         overflow_q <= 1'b0;
         dropped_q  <= '0;
      end else begin
         state_q    <= state_d;
         overflow_q <= overflow_d;
         dropped_q  <= dropped_d;
      end
   end

   trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_ok),
      .pop   (pop_fire),
      .din   (entry_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .count (fifo_count)
   );

   assign head      = trace_entry_t'(fifo_dout);
   assign out_valid = (fifo_count != '0);
   assign out_pc    = head.pc;
   assign out_instr = head.instr;
   assign out_kind  = head.kind;
   assign out_data  = head.data;
   assign out_addr  = head.addr;
   assign state     = state_q;
   assign count     = fifo_count;
   assign overflow  = overflow_q;
   assign dropped   = dropped_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: a queue-based reference model checked every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_retire_trace_buffer;

   localparam int DEPTH = 8;

   logic       clock, reset, arm, disarm, stop_on_full, out_ready;
   logic [7:0] trig_pc, cpu_pc, cpu_instr, cpu_wb_data, cpu_store_data, cpu_alu_out;
   logic       cpu_reg_write, cpu_mem_write;
   logic       out_valid, overflow;
   logic [7:0] out_pc, out_instr, out_data, out_addr, dropped;
   logic [1:0] out_kind, state;
   logic [3:0] count;

   retire_trace_buffer #(.DEPTH(DEPTH)) dut (
      .clock          (clock),
      .reset          (reset),
      .arm            (arm),
      .disarm         (disarm),
      .trig_pc        (trig_pc),
      .stop_on_full   (stop_on_full),
      .cpu_pc         (cpu_pc),
      .cpu_instr      (cpu_instr),
      .cpu_reg_write  (cpu_reg_write),
      .cpu_mem_write  (cpu_mem_write),
      .cpu_wb_data    (cpu_wb_data),
      .cpu_store_data (cpu_store_data),
      .cpu_alu_out    (cpu_alu_out),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_kind       (out_kind),
      .out_data       (out_data),
      .out_addr       (out_addr),
      .state          (state),
      .count          (count),
      .overflow       (overflow),
      .dropped        (dropped)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the trace log as a queue, state as IDLE=0 ARMED=1 RUN=2 DONE=3.
   typedef struct {
      bit [7:0] pc;
      bit [7:0] instr;
      bit [1:0] kind;
      bit [7:0] data;
      bit [7:0] addr;
   } ent_t;

   ent_t mq[$];
   int   mstate;
   bit   movf;
   int   mdrop;

   always @(posedge clock or negedge reset) begin : model_upd
      int   pre;
      bit   attempt;
      ent_t e;
      if (!reset) begin
         mq.delete();
         mstate = 0;
         movf   = 1'b0;
         mdrop  = 0;
      end else begin
         pre = mq.size();
         if (pre > 0 && out_ready) void'(mq.pop_front());
         attempt = 1'b0;
         if (disarm) begin
            mstate = 0;
         end else if (mstate == 0 || mstate == 3) begin
            if (arm) begin
               mstate = 1;
               movf   = 1'b0;
               mdrop  = 0;
            end
         end else if (mstate == 1) begin
            if (cpu_pc == trig_pc) begin
               attempt = 1'b1;
               mstate  = 2;
            end
         end else begin
            attempt = 1'b1;
         end
         if (attempt) begin
            e.pc    = cpu_pc;
            e.instr = cpu_instr;
            e.kind  = {cpu_mem_write, cpu_reg_write};
            e.data  = cpu_mem_write ? cpu_store_data : cpu_wb_data;
            e.addr  = cpu_alu_out;
            if (mq.size() < DEPTH) begin
               mq.push_back(e);
               if (stop_on_full && pre < DEPTH && mq.size() == DEPTH) mstate = 3;
            end else if (stop_on_full) begin
               mstate = 3;
            end else begin
               movf = 1'b1;
               if (mdrop < 255) mdrop++;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (reset) begin
         chk("state", 32'(state), 32'(mstate));
         chk("count", 32'(count), 32'(mq.size()));
         chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
         chk("overflow", 32'(overflow), 32'(movf));
         chk("dropped", 32'(dropped), 32'(mdrop));
         if (mq.size() != 0) begin
            chk("out_pc", 32'(out_pc), 32'(mq[0].pc));
            chk("out_instr", 32'(out_instr), 32'(mq[0].instr));
            chk("out_kind", 32'(out_kind), 32'(mq[0].kind));
            chk("out_data", 32'(out_data), 32'(mq[0].data));
            chk("out_addr", 32'(out_addr), 32'(mq[0].addr));
         end
      end
   end

   task automatic step(input logic [7:0] pc, input logic rw, input logic mw,
                       input logic [7:0] wb, input logic [7:0] sd, input logic [7:0] alu);
      cpu_pc         = pc;
      cpu_instr      = pc ^ 8'hA5;
      cpu_reg_write  = rw;
      cpu_mem_write  = mw;
      cpu_wb_data    = wb;
      cpu_store_data = sd;
      cpu_alu_out    = alu;
      @(negedge clock);
   endtask

   task automatic stepp(input logic [7:0] pc);
      step(pc, pc[0], pc[1], pc + 8'h11, pc ^ 8'h5A, pc + 8'h70);
   endtask

   initial begin
      reset = 1'b0; arm = 1'b0; disarm = 1'b0; stop_on_full = 1'b1; out_ready = 1'b0;
      trig_pc = 8'h02; cpu_pc = 8'h00; cpu_instr = 8'h00; cpu_reg_write = 1'b0;
      cpu_mem_write = 1'b0; cpu_wb_data = 8'h00; cpu_store_data = 8'h00; cpu_alu_out = 8'h00;
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_dropped", 32'(dropped), 32'd0);
      @(negedge clock);
      reset = 1'b1;

      // Trigger at PC 2 with PC sequence 0,1,2,3
      arm = 1'b1; stepp(8'hFF); arm = 1'b0;
      chk("arm_state", 32'(state), 32'd1);
      stepp(8'h00);
      stepp(8'h01);
      chk("pre_trig_count", 32'(count), 32'd0);
      step(8'h02, 1'b1, 1'b0, 8'h0A, 8'h33, 8'h99);
      chk("trig_state", 32'(state), 32'd2);
      chk("trig_count", 32'(count), 32'd1);
      chk("trig_pc", 32'(out_pc), 32'h02);
      chk("reg_kind", 32'(out_kind), 32'd1);
      chk("reg_data", 32'(out_data), 32'h0A);
      step(8'h03, 1'b0, 1'b1, 8'h44, 8'h55, 8'h07);
      chk("run_count", 32'(count), 32'd2);
      disarm = 1'b1; stepp(8'h04); disarm = 1'b0;
      chk("disarm_state", 32'(state), 32'd0);
      chk("disarm_count", 32'(count), 32'd2);
      out_ready = 1'b1; stepp(8'h05);
      chk("store_pc", 32'(out_pc), 32'h03);
      chk("store_kind", 32'(out_kind), 32'd2);
      chk("store_data", 32'(out_data), 32'h55);
      chk("store_addr", 32'(out_addr), 32'h07);
      stepp(8'h06);
      chk("drained_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Stop on full
      trig_pc = 8'h10; stop_on_full = 1'b1;
      arm = 1'b1; stepp(8'hFF); arm = 1'b0;
      for (int i = 0; i < 8; i++) stepp(8'(8'h10 + i));
      chk("sof_count", 32'(count), 32'd8);
      chk("sof_state", 32'(state), 32'd3);
      chk("sof_overflow", 32'(overflow), 32'd0);
      chk("sof_head", 32'(out_pc), 32'h10);
      for (int i = 0; i < 3; i++) stepp(8'(8'h18 + i));
      chk("sof_hold_count", 32'(count), 32'd8);
      chk("sof_hold_state", 32'(state), 32'd3);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) stepp(8'(8'h30 + i));
      chk("sof_drain_count", 32'(count), 32'd0);
      out_ready = 1'b0;

      // Drop mode, then full with simultaneous pop
      trig_pc = 8'h20; stop_on_full = 1'b0;
      arm = 1'b1; stepp(8'hFF); arm = 1'b0;
      for (int i = 0; i < 12; i++) stepp(8'(8'h20 + i));
      chk("drop_count", 32'(count), 32'd8);
      chk("drop_overflow", 32'(overflow), 32'd1);
      chk("drop_dropped", 32'(dropped), 32'd4);
      chk("drop_state", 32'(state), 32'd2);
      chk("drop_head", 32'(out_pc), 32'h20);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) stepp(8'(8'h2C + i));
      out_ready = 1'b0;
      chk("pp_count", 32'(count), 32'd8);
      chk("pp_dropped", 32'(dropped), 32'd4);
      chk("pp_head", 32'(out_pc), 32'h23);
      disarm = 1'b1; stepp(8'hFF); disarm = 1'b0;
      arm = 1'b1; stepp(8'hFF); arm = 1'b0;
      chk("rearm_overflow", 32'(overflow), 32'd0);
      chk("rearm_dropped", 32'(dropped), 32'd0);
      chk("rearm_count", 32'(count), 32'd8);
      disarm = 1'b1; stepp(8'hFF); disarm = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) stepp(8'(8'h60 + i));
      out_ready = 1'b0;
      chk("drop_drain_count", 32'(count), 32'd0);

      // Asynchronous reset mid-capture
      trig_pc = 8'h40;
      arm = 1'b1; stepp(8'hFF); arm = 1'b0;
      for (int i = 0; i < 5; i++) stepp(8'(8'h40 + i));
      chk("pre_rst_count", 32'(count), 32'd5);
      #2 reset = 1'b0;
      #1;
      chk("async_count", 32'(count), 32'd0);
      chk("async_valid", 32'(out_valid), 32'd0);
      chk("async_state", 32'(state), 32'd0);
      @(negedge clock);
      reset = 1'b1;

      // Disarm has priority over arm
      arm = 1'b1; disarm = 1'b1; stepp(8'hFF);
      chk("arm_disarm_idle", 32'(state), 32'd0);
      disarm = 1'b0; stepp(8'hFF); arm = 1'b0;
      trig_pc = 8'h50;
      stepp(8'h50);
      arm = 1'b1; stepp(8'h51);
      chk("arm_in_run_state", 32'(state), 32'd2);
      chk("arm_in_run_count", 32'(count), 32'd2);
      disarm = 1'b1; stepp(8'h52);
      arm = 1'b0; disarm = 1'b0;
      chk("run_disarm_state", 32'(state), 32'd0);
      chk("run_disarm_count", 32'(count), 32'd2);
      stepp(8'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
